// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to the data address are queued in a FIFO
// and shifted out LSB first on tx; a status word is readable at the status address.
module mmio_uart_tx #(
  parameter logic [31:0] ADDR_DATA  = 32'h0000_00F0,
  parameter logic [31:0] ADDR_STAT  = 32'h0000_00F4,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [15:0]   DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic push_req, clr_req, full, empty, div_end, pop, push_ok, ovf_set;
  logic [4:0] count5;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:8];

  assign push_req = memwrite && (dataadr == ADDR_DATA);
  assign clr_req  = memwrite && (dataadr == ADDR_STAT);
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign div_end  = (div_q == DIV_LAST);

  // Head is consumed either from idle or at the very end of a stop bit (back-to-back frames).
  assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && div_end));
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[tail_q] = writedata[7:0];
    end
    overflow_d = overflow_q;
    if (clr_req) begin
      overflow_d = 1'b0;
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          shift_d = mem_q[head_q];
          div_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      S_DATA: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      S_STOP: begin
        if (div_end) begin
          div_d = '0;
          if (!empty) begin
            shift_d = mem_q[head_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count/pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    count5            = '0;
    count5[CW-1:0]    = count_q;
  end

  assign hit      = (dataadr == ADDR_DATA) || (dataadr == ADDR_STAT);
  assign rdata    = (dataadr == ADDR_STAT) ?
                    {23'd0, count5, overflow_q, empty, full, busy} : 32'd0;
  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: accepted bytes are queued when stored and
// compared against frames decoded from tx.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_DATA = 32'h0000_00F0;
  localparam logic [31:0] A_STAT = 32'h0000_00F4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        hit;
  logic [31:0] rdata;
  logic        tx, busy, overflow;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [7:0] sb[$];
  int starts[$];
  logic [7:0]  rx;
  logic [31:0] exp_b;
  int ns;

  mmio_uart_tx #(
    .ADDR_DATA (A_DATA),
    .ADDR_STAT (A_STAT),
    .CLK_DIV   (4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memwrite (memwrite),
    .dataadr  (dataadr),
    .writedata(writedata),
    .hit      (hit),
    .rdata    (rdata),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    memwrite  = 1'b0;
    dataadr   = 32'd0;
    writedata = 32'd0;
  endtask

  task automatic rd_stat(input string tag, input logic [31:0] exp);
    memwrite = 1'b0;
    dataadr  = A_STAT;
    #1 chk(tag, rdata, exp);
  endtask

  // Serial monitor: frame detected at its first low cycle, bits sampled mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst && tx === 1'b0) begin
        starts.push_back(cyc);
        repeat (2) @(negedge clk);
        chk("start_bit", {31'd0, tx}, 32'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) repeat (4) @(negedge clk);
          rx[i] = tx;
        end
        repeat (4) @(negedge clk);
        chk("stop_bit", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        exp_b = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD;
        chk("rx_byte", {24'd0, rx}, exp_b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rd_stat("rst_stat", 32'h0000_0004);
    @(negedge clk) rst = 1'b1;

    // Reset mid-frame (0xA5: bit1 is low)
    bus_wr(A_DATA, 32'h0000_00A5);
    bus_idle();
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rd_stat("mid_rst_stat", 32'h0000_0004);
    repeat (3) @(negedge clk);
    chk("hold_rst_tx", {31'd0, tx}, 32'd1);
    rst = 1'b1;
    mon_en = 1'b1;

    // Decode and ignored writes
    dataadr = 32'h0000_0100;
    #1 chk("hit_other", {31'd0, hit}, 32'd0);
    chk("rdata_other", rdata, 32'd0);
    dataadr = A_DATA;
    #1 chk("hit_data", {31'd0, hit}, 32'd1);
    chk("rdata_data", rdata, 32'd0);
    bus_wr(32'h0000_00F8, 32'h0000_0055);
    bus_idle();
    repeat (2) @(negedge clk);
    chk("ign_busy", {31'd0, busy}, 32'd0);
    rd_stat("ign_stat", 32'h0000_0004);

    // Single byte with latency and frame length
    bus_wr(A_DATA, 32'h1234_5655);
    sb.push_back(8'h55);
    bus_idle();
    chk("lat_pre_tx", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    chk("lat_start_tx", {31'd0, tx}, 32'd0);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    repeat (39) @(posedge clk);
    #1;
    chk("busy_end", {31'd0, busy}, 32'd1);
    chk("stop_tx", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    chk("busy_drop", {31'd0, busy}, 32'd0);

    // Back-to-back frames
    repeat (2) @(posedge clk);
    ns = starts.size();
    bus_wr(A_DATA, 32'h41); sb.push_back(8'h41);
    bus_wr(A_DATA, 32'h42); sb.push_back(8'h42);
    bus_wr(A_DATA, 32'h43); sb.push_back(8'h43);
    bus_idle();
    rd_stat("b2b_cnt2", 32'h0000_0021);
    repeat (40) @(posedge clk);
    rd_stat("b2b_cnt1", 32'h0000_0011);
    repeat (40) @(posedge clk);
    rd_stat("b2b_cnt0", 32'h0000_0005);
    repeat (40) @(posedge clk);
    #1 chk("b2b_idle", {31'd0, busy}, 32'd0);
    chk("b2b_frames", starts.size() - ns, 32'd3);
    if (starts.size() - ns == 3) begin
      chk("b2b_gap1", starts[ns+1] - starts[ns], 32'd40);
      chk("b2b_gap2", starts[ns+2] - starts[ns+1], 32'd40);
    end

    // Overflow: 10 pushes, first one popped immediately, 8 stored, last dropped
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      bus_wr(A_DATA, 32'h60 + i);
      if (i < 9) sb.push_back(8'(8'h60 + i));
    end
    @(posedge clk);
    #1 chk("ovf_set", {31'd0, overflow}, 32'd1);
    rd_stat("ovf_stat", 32'h0000_008B);
    bus_wr(A_STAT, 32'hFFFF_FFFF);
    bus_idle();
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    rd_stat("clr_stat", 32'h0000_0083);
    repeat (29) bus_idle();

    // Push while full at the exact edge the FSM pops
    @(negedge clk);
    rd_stat("pre_pop_full", 32'h0000_0083);
    memwrite  = 1'b1;
    dataadr   = A_DATA;
    writedata = 32'h0000_0077;
    sb.push_back(8'h77);
    @(posedge clk);
    #1;
    chk("simul_ovf", {31'd0, overflow}, 32'd0);
    chk("simul_tx", {31'd0, tx}, 32'd0);
    rd_stat("simul_stat", 32'h0000_0083);

    // Drain everything
    for (int k = 0; k < 3000 && (sb.size() != 0 || busy); k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_sb", sb.size(), 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_tx", {31'd0, tx}, 32'd1);
    rd_stat("drain_stat", 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
